md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_if.sv | 25 ++
 rtl/md_sequencer.sv | 133 +++++++++++++
 tb/tb_md_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer bus: EX-stage request, ID-stage use hint,
// and the HI/LO results, stall and status handed back to the pipeline.
interface md_sequencer_if;
  logic [2:0]  md_func;
  logic        md_sign;
  logic        md_valid;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_md_use;
  logic        md_stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_func, md_sign, md_valid, rs_val, rt_val, id_md_use,
    input  md_stall, md_busy, md_done, hi, lo
  );

  modport slave (
    input  md_func, md_sign, md_valid, rs_val, rt_val, id_md_use,
    output md_stall, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer for a MIPS-style pipeline.
// The result is computed when the operation starts and held in a buffer;
// it reaches HI/LO only after the fixed run length (5 cycles mult,
// 10 cycles div). mthi/mtlo write HI/LO directly when idle.
// Optional feature: define MD_DIVZERO_EN to give divide-by-zero a
// 1-cycle run that commits HI=rs, LO=all ones. Without it, divide by zero
// runs the full 10 cycles and leaves HI/LO unchanged.
module md_sequencer (
  input logic          clk,
  input logic          reset,
  md_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_MUL = 2'd1;
  localparam logic [1:0] RUN_DIV = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] buf_hi;
  logic [31:0] buf_lo;
  logic        done_q;

  logic        is_mul;
  logic        is_div;
  logic        start;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] uquo;
  logic [31:0] urem;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [3:0]  res_cnt;

  assign is_mul = (bus.md_func == 3'd3);
  assign is_div = (bus.md_func == 3'd4);
  assign start  = bus.md_valid && (is_mul || is_div) && (state == IDLE);

  // Compute the full result from the EX operands so it can be buffered at start
  always_comb begin
    ext_a  = {{32{bus.md_sign & bus.rs_val[31]}}, bus.rs_val};
    ext_b  = {{32{bus.md_sign & bus.rt_val[31]}}, bus.rt_val};
    prod   = ext_a * ext_b;

    neg_a  = bus.md_sign & bus.rs_val[31];
    neg_b  = bus.md_sign & bus.rt_val[31];
    div_a  = neg_a ? -bus.rs_val : bus.rs_val;
    div_b  = (bus.rt_val == 32'd0) ? 32'd1 : (neg_b ? -bus.rt_val : bus.rt_val);
    uquo   = div_a / div_b;
    urem   = div_a % div_b;
    quo    = (neg_a ^ neg_b) ? -uquo : uquo;
    rem    = neg_a ? -urem : urem;

    res_hi  = rem;
    res_lo  = quo;
    res_cnt = 4'd9;
    if (is_mul) begin
      res_hi  = prod[63:32];
      res_lo  = prod[31:0];
      res_cnt = 4'd4;
    end else if (bus.rt_val == 32'd0) begin
`ifdef MD_DIVZERO_EN
      res_hi  = bus.rs_val;
      res_lo  = 32'hFFFF_FFFF;
      res_cnt = 4'd0;
`else
      res_hi  = hi_q;
      res_lo  = lo_q;
      res_cnt = 4'd9;
`endif
    end
  end

  // Sequencer state, run counter, result buffer and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      buf_hi <= 32'd0;
      buf_lo <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            buf_hi <= res_hi;
            buf_lo <= res_lo;
            cnt    <= res_cnt;
            state  <= is_mul ? RUN_MUL : RUN_DIV;
          end else if (bus.md_valid && bus.md_func == 3'd1) begin
            hi_q <= bus.rs_val;
          end else if (bus.md_valid && bus.md_func == 3'd2) begin
            lo_q <= bus.rs_val;
          end
        end
        RUN_MUL, RUN_DIV: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            hi_q   <= buf_hi;
            lo_q   <= buf_lo;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.md_busy  = (state != IDLE);
  assign bus.md_done  = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_stall = reset && bus.id_md_use && (start || (state != IDLE));

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: each mult/div pushes its expected
// {HI,LO} when issued; a monitor pops and compares on every md_done.
// Honours MD_DIVZERO_EN for the divide-by-zero expectations.
module tb_md_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  md_sequencer_if bus ();

  md_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pop the scoreboard whenever the sequencer commits
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.md_done === 1'b1) begin
      checkOutput("scoreboard depth at md_done", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("hi at commit", 64'(bus.hi), 64'(mon_exp[63:32]));
        checkOutput("lo at commit", 64'(bus.lo), 64'(mon_exp[31:0]));
      end
    end
  end

  // mthi/mtlo (or an ignored func code) issued for one cycle while idle
  task automatic applyMove(input logic [2:0] func, input logic [31:0] rs);
    @(negedge clk);
    bus.md_func  = func;
    bus.md_valid = 1'b1;
    bus.rs_val   = rs;
    @(negedge clk);
    bus.md_valid = 1'b0;
    bus.md_func  = 3'd0;
    if (func == 3'd1) model_hi = rs;
    if (func == 3'd2) model_lo = rs;
    checkOutput("move hi", 64'(bus.hi), 64'(model_hi));
    checkOutput("move lo", 64'(bus.lo), 64'(model_lo));
    checkOutput("move busy", 64'(bus.md_busy), 64'd0);
    @(negedge clk);
    checkOutput("move busy later", 64'(bus.md_busy), 64'd0);
    checkOutput("move done", 64'(bus.md_done), 64'd0);
  endtask

  // Issue one mult/div, push the expected result, and track its timing
  task automatic applyStimulus(input logic [2:0] func, input logic sign,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic use_id, input logic inject,
                               input string tag);
    logic [63:0] expv;
    logic [63:0] prev;
    longint      a;
    longint      b;
    int          sa;
    int          sbv;
    int          q;
    int          r;
    int          n_run;
    int          lat;

    sa  = rs;
    sbv = rt;
    if (func == 3'd3) begin
      a     = sign ? longint'(sa)  : longint'({32'd0, rs});
      b     = sign ? longint'(sbv) : longint'({32'd0, rt});
      expv  = 64'(a * b);
      n_run = 5;
    end else begin
      n_run = 10;
      if (rt == 32'd0) begin
`ifdef MD_DIVZERO_EN
        expv  = {rs, 32'hFFFF_FFFF};
        n_run = 1;
`else
        expv  = {model_hi, model_lo};
`endif
      end else if (sign) begin
        q    = sa / sbv;
        r    = sa % sbv;
        expv = {32'(r), 32'(q)};
      end else begin
        expv = {rs % rt, rs / rt};
      end
    end

    prev = {model_hi, model_lo};
    exp_q.push_back(expv);
    model_hi = expv[63:32];
    model_lo = expv[31:0];

    @(negedge clk);
    bus.md_func   = func;
    bus.md_sign   = sign;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.md_valid  = 1'b1;
    bus.id_md_use = use_id;
    #1;
    if (use_id) checkOutput({tag, " stall in start cycle"}, 64'(bus.md_stall), 64'd1);

    @(negedge clk);
    bus.md_valid = 1'b0;
    bus.md_func  = 3'd0;
    lat = 1;
    while (bus.md_done !== 1'b1 && lat < 40) begin
      checkOutput({tag, " busy"}, 64'(bus.md_busy), 64'd1);
      if (use_id) checkOutput({tag, " stall"}, 64'(bus.md_stall), 64'd1);
      if (lat == n_run) checkOutput({tag, " hi/lo held"}, {bus.hi, bus.lo}, prev);
      if (inject) begin
        if (lat == 2) begin
          bus.md_valid = 1'b1;
          bus.md_func  = 3'd3;
          bus.rs_val   = 32'd5;
          bus.rt_val   = 32'd5;
        end else if (lat == 3) begin
          bus.md_func  = 3'd1;
          bus.rs_val   = 32'hDEAD_BEEF;
        end else if (lat == 4) begin
          bus.md_valid = 1'b0;
          bus.md_func  = 3'd0;
        end
      end
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(n_run + 1));
    checkOutput({tag, " busy after"}, 64'(bus.md_busy), 64'd0);
    if (use_id) checkOutput({tag, " stall after"}, 64'(bus.md_stall), 64'd0);
    bus.id_md_use = 1'b0;
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, 64'(bus.md_done), 64'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;

    reset         = 1'b0;
    bus.md_func   = 3'd3;
    bus.md_sign   = 1'b0;
    bus.md_valid  = 1'b1;
    bus.rs_val    = 32'd9;
    bus.rt_val    = 32'd9;
    bus.id_md_use = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    checkOutput("reset busy", 64'(bus.md_busy), 64'd0);
    checkOutput("reset done", 64'(bus.md_done), 64'd0);
    checkOutput("reset stall", 64'(bus.md_stall), 64'd0);
    bus.md_valid  = 1'b0;
    bus.md_func   = 3'd0;
    bus.id_md_use = 1'b0;
    reset         = 1'b1;

    applyMove(3'd1, 32'h1234_5678);
    applyMove(3'd2, 32'hCAFE_BABE);

    applyStimulus(3'd3, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, "mult signed");
    checkOutput("mult signed hi", 64'(bus.hi), 64'hFFFF_FFFF);
    checkOutput("mult signed lo", 64'(bus.lo), 64'hFFFF_FFFA);

    applyStimulus(3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu max");
    applyStimulus(3'd4, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, "divu 100/7");
    checkOutput("divu lo", 64'(bus.lo), 64'd14);
    checkOutput("divu hi", 64'(bus.hi), 64'd2);
    applyStimulus(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div -7/2");
    checkOutput("div signed lo", 64'(bus.lo), 64'(32'hFFFF_FFFD));
    checkOutput("div signed hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
    applyStimulus(3'd4, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, "div 7/-2");
    applyStimulus(3'd4, 1'b0, 32'h0000_0055, 32'd0, 1'b0, 1'b0, "div by zero");

    applyMove(3'd5, 32'h0BAD_0BAD);
    applyMove(3'd7, 32'h0BAD_0BAD);

    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 3'd3 : 3'd4, 1'($urandom_range(0, 1)),
                    $urandom(), $urandom_range(1, 65535), 1'b0, 1'b0, "random op");
    end

    applyMove(3'd1, 32'hA5A5_0001);

    // Reset in the third run cycle of a divide
    @(negedge clk);
    bus.md_func  = 3'd4;
    bus.md_sign  = 1'b0;
    bus.rs_val   = 32'd1000;
    bus.rt_val   = 32'd3;
    bus.md_valid = 1'b1;
    @(negedge clk);
    bus.md_valid = 1'b0;
    bus.md_func  = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset busy", 64'(bus.md_busy), 64'd1);
    reset         = 1'b0;
    bus.id_md_use = 1'b1;
    bus.md_valid  = 1'b1;
    bus.md_func   = 3'd3;
    #1;
    checkOutput("mid-op reset hi", 64'(bus.hi), 64'd0);
    checkOutput("mid-op reset lo", 64'(bus.lo), 64'd0);
    checkOutput("mid-op reset busy", 64'(bus.md_busy), 64'd0);
    checkOutput("mid-op reset stall", 64'(bus.md_stall), 64'd0);
    @(negedge clk);
    reset         = 1'b1;
    bus.md_valid  = 1'b0;
    bus.md_func   = 3'd0;
    bus.id_md_use = 1'b0;
    model_hi      = 32'd0;
    model_lo      = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("post-reset busy", 64'(bus.md_busy), 64'd0);
    end
    checkOutput("post-reset hi", 64'(bus.hi), 64'd0);

    applyStimulus(3'd3, 1'b0, 32'd6, 32'd7, 1'b0, 1'b0, "mult after reset");

    checkOutput("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
